// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: D/E/M hazard inputs, stall/enable outputs,
// mult/div occupancy and the stall performance counter.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       D_rs;
    logic [4:0]       D_rt;
    logic [1:0]       D_Tuse_rs;
    logic [1:0]       D_Tuse_rt;
    logic             D_is_md;
    logic             E_regwe;
    logic [4:0]       E_A3;
    logic [1:0]       E_Tnew;
    logic             M_regwe;
    logic [4:0]       M_A3;
    logic [1:0]       M_Tnew;
    logic             E_md_start;
    logic             E_md_isdiv;
    logic             stall;
    logic             F_en;
    logic             D_en;
    logic             E_clr;
    logic             md_busy;
    logic [3:0]       md_cnt;
    logic [CNT_W-1:0] stall_count;
    // Debug view of the mult/div FSM state (0 = IDLE, 1 = BUSY).
    logic             md_state;

    // No valid/ready pairs here: every signal is a level qualified by the
    // pipeline clock, sampled or driven once per cycle.
    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
        output E_regwe, E_A3, E_Tnew, M_regwe, M_A3, M_Tnew,
        output E_md_start, E_md_isdiv,
        input  stall, F_en, D_en, E_clr, md_busy, md_cnt, stall_count, md_state
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
        input  E_regwe, E_A3, E_Tnew, M_regwe, M_A3, M_Tnew,
        input  E_md_start, E_md_isdiv,
        output stall, F_en, D_en, E_clr, md_busy, md_cnt, stall_count, md_state
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: Tuse/Tnew data-hazard detection, mult/div busy window FSM,
// and a saturating count of stalled cycles.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             rs_hazard, rt_hazard, md_hazard, stall_w;

    always_comb begin
        rs_hazard = (bus.D_rs != 5'd0) &&
                    ((bus.E_regwe && (bus.E_A3 == bus.D_rs) && (bus.E_Tnew > bus.D_Tuse_rs)) ||
                     (bus.M_regwe && (bus.M_A3 == bus.D_rs) && (bus.M_Tnew > bus.D_Tuse_rs)));
        rt_hazard = (bus.D_rt != 5'd0) &&
                    ((bus.E_regwe && (bus.E_A3 == bus.D_rt) && (bus.E_Tnew > bus.D_Tuse_rt)) ||
                     (bus.M_regwe && (bus.M_A3 == bus.D_rt) && (bus.M_Tnew > bus.D_Tuse_rt)));
        md_hazard = bus.D_is_md && ((state_q == BUSY) || bus.E_md_start);
        // Held in reset the pipeline must free-run, so the stall is gated off.
        stall_w   = reset && (rs_hazard || rt_hazard || md_hazard);
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.E_md_start) begin
                    state_d  = BUSY;
                    md_cnt_d = bus.E_md_isdiv ? DIV_LD : MULT_LD;
                end
            end
            BUSY: begin
                // A start seen here is a protocol violation and is ignored.
                if (md_cnt_q == 4'd1) begin
                    state_d  = IDLE;
                    md_cnt_d = 4'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_w && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            md_cnt_q      <= 4'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall       = stall_w;
    assign bus.F_en        = ~stall_w;
    assign bus.D_en        = ~stall_w;
    assign bus.E_clr       = stall_w;
    assign bus.md_busy     = (state_q == BUSY);
    assign bus.md_cnt      = md_cnt_q;
    assign bus.stall_count = stall_count_q;
    assign bus.md_state    = (state_q == BUSY);
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: per-cycle expected output bundles are queued
// as stimulus is driven and popped when the outputs are sampled on the falling edge.
module tb_hazard_stall_ctrl;
    localparam int CNT_W = 4;
    localparam int EW    = 14;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       is_md;
        logic       e_we;
        logic [4:0] e_a3;
        logic [1:0] e_tnew;
        logic       m_we;
        logic [4:0] m_a3;
        logic [1:0] m_tnew;
        logic       start;
        logic       isdiv;
    } stim_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    int            total = 0;
    int            bad = 0;
    logic [EW-1:0] exp_q[$];

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Expected bundle: {stall, F_en, D_en, E_clr, md_busy, md_state, md_cnt, stall_count}.
    function automatic logic [EW-1:0] expv(input logic st, input logic busy,
                                           input logic [3:0] cnt, input logic [CNT_W-1:0] sc);
        return {st, ~st, ~st, st, busy, busy, cnt, sc};
    endfunction

    function automatic logic [EW-1:0] observe();
        return {bus.stall, bus.F_en, bus.D_en, bus.E_clr, bus.md_busy, bus.md_state,
                bus.md_cnt, bus.stall_count};
    endfunction

    task automatic drive_in(input stim_t s);
        bus.D_rs       = s.rs;
        bus.D_rt       = s.rt;
        bus.D_Tuse_rs  = s.tuse_rs;
        bus.D_Tuse_rt  = s.tuse_rt;
        bus.D_is_md    = s.is_md;
        bus.E_regwe    = s.e_we;
        bus.E_A3       = s.e_a3;
        bus.E_Tnew     = s.e_tnew;
        bus.M_regwe    = s.m_we;
        bus.M_A3       = s.m_a3;
        bus.M_Tnew     = s.m_tnew;
        bus.E_md_start = s.start;
        bus.E_md_isdiv = s.isdiv;
    endtask

    task automatic do_reset();
        drive_in('0);
        reset = 1'b0;
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        logic [EW-1:0] got, want;
        for (int c = 0; c < 3; c++) begin
            s = '0;
            if (c < 2) begin
                s.e_we = 1'b1; s.e_a3 = 5'd8; s.e_tnew = 2'd2; s.rs = 5'd8; s.tuse_rs = 2'd1;
                s.is_md = 1'b1; s.start = 1'b1;
            end
            drive_in(s);
            if (c == 2) reset = 1'b1;
            exp_q.push_back(expv(1'b0, 1'b0, 4'd0, '0));
            if (c == 0) #2; else @(negedge clk);
            got = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_data_hazard();
        stim_t s;
        logic [EW-1:0] got, want;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            s = '0;
            case (c)
                0: begin s.e_we = 1; s.e_a3 = 8; s.e_tnew = 2; s.rs = 8; s.tuse_rs = 1;
                         s.tuse_rt = 3; exp_q.push_back(expv(1, 0, 0, 4'd0)); end
                1: begin s.m_we = 1; s.m_a3 = 8; s.m_tnew = 1; s.rs = 8; s.tuse_rs = 1;
                         exp_q.push_back(expv(0, 0, 0, 4'd1)); end
                2: begin s.m_we = 1; s.m_a3 = 8; s.m_tnew = 2; s.rs = 8; s.tuse_rs = 1;
                         exp_q.push_back(expv(1, 0, 0, 4'd1)); end
                3: begin s.e_we = 1; s.e_a3 = 5; s.e_tnew = 1; s.rt = 5; s.tuse_rt = 0;
                         exp_q.push_back(expv(1, 0, 0, 4'd2)); end
                4: begin s.e_we = 1; s.e_a3 = 5; s.e_tnew = 1; s.rt = 5; s.tuse_rt = 1;
                         exp_q.push_back(expv(0, 0, 0, 4'd3)); end
                5: begin s.e_we = 1; s.e_a3 = 5; s.e_tnew = 0; s.rt = 5;
                         exp_q.push_back(expv(0, 0, 0, 4'd3)); end
                6: begin s.e_we = 0; s.e_a3 = 5; s.e_tnew = 2; s.rt = 5;
                         exp_q.push_back(expv(0, 0, 0, 4'd3)); end
                7: begin s.e_we = 1; s.e_a3 = 9; s.e_tnew = 2; s.rs = 8;
                         exp_q.push_back(expv(0, 0, 0, 4'd3)); end
                8: begin s.m_we = 1; s.m_a3 = 7; s.m_tnew = 2; s.rt = 7; s.tuse_rt = 1;
                         s.e_we = 1; s.e_a3 = 6; s.e_tnew = 2;
                         exp_q.push_back(expv(1, 0, 0, 4'd3)); end
                default: exp_q.push_back(expv(0, 0, 0, 4'd4));
            endcase
            drive_in(s);
            @(negedge clk);
            got = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL data_hazard cyc=%0d got=%h exp=%h", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_zero_reg_tuse();
        stim_t s;
        logic [EW-1:0] got, want;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            s = '0;
            case (c)
                0: begin s.rs = 0; s.e_we = 1; s.e_a3 = 0; s.e_tnew = 2; s.tuse_rs = 0;
                         exp_q.push_back(expv(0, 0, 0, 4'd0)); end
                1: begin s.rt = 9; s.tuse_rt = 3; s.e_we = 1; s.e_a3 = 9; s.e_tnew = 2;
                         exp_q.push_back(expv(0, 0, 0, 4'd0)); end
                2: begin s.rt = 9; s.tuse_rt = 3; s.m_we = 1; s.m_a3 = 9; s.m_tnew = 2;
                         exp_q.push_back(expv(0, 0, 0, 4'd0)); end
                3: begin s.rt = 9; s.tuse_rt = 1; s.e_we = 1; s.e_a3 = 9; s.e_tnew = 2;
                         exp_q.push_back(expv(1, 0, 0, 4'd0)); end
                default: exp_q.push_back(expv(0, 0, 0, 4'd1));
            endcase
            drive_in(s);
            @(negedge clk);
            got = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL zero_reg_tuse cyc=%0d got=%h exp=%h", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div();
        stim_t s;
        logic [EW-1:0] got, want;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            s = '0;
            s.is_md = (c < 12);
            if (c == 0) begin
                s.start = 1; s.isdiv = 1;
                exp_q.push_back(expv(1, 0, 0, 4'd0));
            end else if (c <= 10) begin
                exp_q.push_back(expv(1, 1, 4'(11 - c), 4'(c)));
            end else begin
                exp_q.push_back(expv(0, 0, 0, 4'd11));
            end
            drive_in(s);
            @(negedge clk);
            got = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL div_window cyc=%0d got=%h exp=%h", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mult_reload();
        stim_t s;
        logic [EW-1:0] got, want;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            s = '0;
            if (c == 0 || c == 7) begin
                s.start = 1; s.isdiv = 0;
                exp_q.push_back(expv(0, 0, 0, 4'd0));
            end else if (c <= 5) begin
                if (c == 3) begin s.start = 1; s.isdiv = 1; end
                exp_q.push_back(expv(0, 1, 4'(6 - c), 4'd0));
            end else if (c == 6) begin
                exp_q.push_back(expv(0, 0, 0, 4'd0));
            end else begin
                exp_q.push_back(expv(0, 1, 4'd5, 4'd0));
            end
            drive_in(s);
            @(negedge clk);
            got = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL mult_reload cyc=%0d got=%h exp=%h", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_saturate_and_reset();
        stim_t s;
        logic [EW-1:0] got, want;
        do_reset();
        for (int c = 0; c < 102; c++) begin
            s = '0;
            s.e_we = 1; s.e_a3 = 8; s.e_tnew = 2; s.rs = 8; s.tuse_rs = 0;
            if (c == 99) begin s.start = 1; s.isdiv = 1; end
            if (c <= 99)       exp_q.push_back(expv(1, 0, 0, (c > 15) ? 4'd15 : 4'(c)));
            else if (c == 100) exp_q.push_back(expv(1, 1, 4'd10, 4'd15));
            else               exp_q.push_back(expv(1, 1, 4'd9, 4'd15));
            drive_in(s);
            @(negedge clk);
            got = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL saturate cyc=%0d got=%h exp=%h", c, got, want);
            end
            @(posedge clk);
            #1;
        end
        // Reset mid-BUSY with the hazard still applied: outputs clear without a clock edge.
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(expv(0, 0, 0, 4'd0));
            if (c == 0) begin
                reset = 1'b0;
                #1;
            end else begin
                if (c == 1) begin
                    drive_in('0);
                    reset = 1'b1;
                end
                @(negedge clk);
            end
            got = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL async_reset step=%0d got=%h exp=%h", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        drive_in('0);
        test_reset();
        test_data_hazard();
        test_zero_reg_tuse();
        test_div();
        test_mult_reload();
        test_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush controller for the five-stage pipeline. Sequences the F/D/E pipeline registers.
- Compares D-stage source registers (Tuse) against in-flight E/M-stage destinations (A3, regwe, Tnew). Tracks the multi-cycle mult/div unit's busy window.
- Drives the enable for PC and D_reg, and the clear for E_reg. Maintains a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (must be >=1)
- DIV_CYCLES, 10, busy cycles after a div/divu start (must be >=1)
- CNT_W, 32, width of stall performance counter

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low reset
- D_rs  input  5  rs address of instruction in D
- D_rt  input  5  rt address of instruction in D
- D_Tuse_rs  input  2  cycles until D needs rs (3 = not used)
- D_Tuse_rt  input  2  cycles until D needs rt (3 = not used)
- D_is_md  input  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_regwe  input  1  E instruction writes GPR
- E_A3  input  5  E destination register
- E_Tnew  input  2  cycles until E result is available
- M_regwe  input  1  M instruction writes GPR
- M_A3  input  5  M destination register
- M_Tnew  input  2  cycles until M result is available
- E_md_start  input  1  E instruction is a mult/div start this cycle
- E_md_isdiv  input  1  with E_md_start: 1 = div/divu, 0 = mult/multu
- stall  output  1  hazard present this cycle
- F_en  output  1  PC write enable (= ~stall)
- D_en  output  1  D_reg load enable (= ~stall)
- E_clr  output  1  E_reg synchronous clear / bubble insert (= stall)
- md_busy  output  1  mult/div unit occupied
- md_cnt  output  4  remaining busy cycles
- stall_count  output  CNT_W  total stalled cycles since reset, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, md_cnt=0, md_busy=0, stall_count=0. While reset=0, stall=0, F_en=1, D_en=1, E_clr=0 (combinationally forced).
- Data hazard, rs (combinational): D_rs!=0 AND ((E_regwe AND E_A3==D_rs AND E_Tnew>D_Tuse_rs) OR (M_regwe AND M_A3==D_rs AND M_Tnew>D_Tuse_rs)).
- Data hazard, rt: identical form with D_rt and D_Tuse_rt.
- Register $0 never causes a hazard. Tnew==0 never stalls. A Tuse of 3 never stalls, since Tnew is at most 2.
- md hazard: D_is_md AND (md_busy OR E_md_start).
- stall = rs_hazard OR rt_hazard OR md_hazard. Same-cycle combinational output, no latency.
- FSM, two states:
  - IDLE: on E_md_start, go to BUSY. md_cnt loads DIV_CYCLES if E_md_isdiv, else MULT_CYCLES.
  - BUSY: md_cnt decrements by 1 each cycle. When md_cnt==1 at a clock edge, go to IDLE and set md_cnt=0.
  - md_busy = (state==BUSY). md_busy rises the cycle after E_md_start.
  - E_md_start while in BUSY is a protocol violation (prevented by md_hazard). The block ignores it: no reload, no state change.
- With MULT_CYCLES=5, md_busy is high for exactly 5 cycles after the start edge.
- md_cnt width 4: parameters above 15 are illegal.
- stall_count increments by 1 at each rising edge where stall=1. It holds at 2^CNT_W-1 (no wrap).
- Stall and md start in the same cycle: the start still registers, because the E_reg clear takes effect at the same edge that the FSM samples E_md_start.
- Reset asserted mid-BUSY: md_busy drops immediately, md_cnt=0, no residual stall after reset is released.

Test Plan:
1. Reset then release; all inputs 0 -> stall=0, F_en=D_en=1, E_clr=0, md_busy=0, stall_count=0.
2. E: regwe=1, A3=8, Tnew=2; D: rs=8, Tuse_rs=1 -> stall=1, E_clr=1 for one cycle. Next cycle the same instruction is in M with Tnew=1 -> stall=0, and stall_count=1.
3. D_rs=0 with E_A3=0, E_regwe=1, E_Tnew=2, Tuse=0 -> stall=0. D_rt=9, Tuse_rt=3, E_A3=9, E_Tnew=2 -> stall=0.
4. E_md_start=1, E_md_isdiv=1 for one cycle -> md_busy=1 for exactly 10 cycles with md_cnt 10,9,...,1, then 0. A D_is_md instruction held in D during that window gives stall=1 for 11 cycles (start cycle plus 10), and stall_count=11.
5. Mult start (E_md_isdiv=0) -> md_busy for 5 cycles. A second E_md_start injected during cycle 3 -> no reload, md_busy drops after the original 5 cycles.
6. Force stall=1 for 100 cycles with CNT_W=4 -> stall_count saturates at 15. Assert reset=0 mid-BUSY -> md_busy=0 and stall_count=0 immediately, without waiting for a clock edge.
